// File: rtl/dbg_program_loader.sv
// Program loader for the core's debug write port: accepts instruction words on a
// valid/ready stream and writes each one with setup/strobe/hold timing while the core is held in reset.
module dbg_program_loader #(
   parameter int  XLEN         = 32,
   parameter int  DEPTH        = 256,
   parameter int  ADDR_STEP    = 4,
   parameter int  SETUP_CYCLES = 2,
   parameter int  WR_CYCLES    = 1,
   parameter int  HOLD_CYCLES  = 1,
   localparam int CW           = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic            release_en,
   input  logic [XLEN-1:0] base_addr,
   input  logic [CW-1:0]   word_count,
   input  logic            in_valid,
   input  logic [XLEN-1:0] in_data,
   output logic            in_ready,
   output logic            dbg_wr_en,
   output logic [XLEN-1:0] dbg_addr,
   output logic [XLEN-1:0] dbg_instr,
   output logic            core_rst,
   output logic            busy,
   output logic            done,
   output logic            error
);

   localparam int MAX_A     = (SETUP_CYCLES > WR_CYCLES) ? SETUP_CYCLES : WR_CYCLES;
   localparam int MAX_PHASE = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
   localparam int TW        = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_SETUP  = 3'd2,
      ST_WRITE  = 3'd3,
      ST_HOLD   = 3'd4,
      ST_FINISH = 3'd5
   } state_t;

   state_t          state_r;
   state_t          state_next_s;
   logic [TW-1:0]   timer_r;
   logic [CW-1:0]   index_r;
   logic [CW-1:0]   count_r;
   logic            rel_r;
   logic [XLEN-1:0] addr_acc_r;
   logic [XLEN-1:0] dbg_addr_r;
   logic [XLEN-1:0] dbg_instr_r;
   logic            dbg_wr_en_r;
   logic            core_rst_r;
   logic            busy_r;
   logic            done_r;
   logic            error_r;
   logic            start_ok_s;
   logic            start_bad_s;
   logic            abort_s;
   logic            handshake_s;
   logic            advance_s;
   logic            last_s;

   // Next-state decode and per-cycle event strobes
   always_comb begin
      state_next_s = state_r;
      start_ok_s   = 1'b0;
      start_bad_s  = 1'b0;
      abort_s      = 1'b0;
      handshake_s  = 1'b0;
      advance_s    = 1'b0;
      last_s       = (index_r == (count_r - CW'(1)));
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               if ((word_count != CW'(0)) && (word_count <= CW'(DEPTH))) begin
                  start_ok_s   = 1'b1;
                  state_next_s = ST_FETCH;
               end else begin
                  start_bad_s  = 1'b1;
               end
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (in_valid) begin
               handshake_s  = 1'b1;
               state_next_s = ST_SETUP;
            end else begin
               state_next_s = ST_FETCH;
            end
         end
         ST_SETUP: begin
            if (timer_r == TW'(SETUP_CYCLES - 1)) begin
               state_next_s = ST_WRITE;
            end else begin
               state_next_s = ST_SETUP;
            end
         end
         ST_WRITE: begin
            if (timer_r == TW'(WR_CYCLES - 1)) begin
               state_next_s = ST_HOLD;
            end else begin
               state_next_s = ST_WRITE;
            end
         end
         ST_HOLD: begin
            if (timer_r == TW'(HOLD_CYCLES - 1)) begin
               if (last_s) begin
                  state_next_s = ST_FINISH;
               end else begin
                  advance_s    = 1'b1;
                  state_next_s = ST_FETCH;
               end
            end else begin
               state_next_s = ST_HOLD;
            end
         end
         ST_FINISH: state_next_s = ST_IDLE;
         default:   state_next_s = ST_IDLE;
      endcase
      // Abort overrides every transition, including completion out of HOLD
      if (abort && (state_r != ST_IDLE)) begin
         abort_s      = 1'b1;
         handshake_s  = 1'b0;
         advance_s    = 1'b0;
         state_next_s = ST_IDLE;
      end else begin
         abort_s      = 1'b0;
      end
   end

   // State register and phase timer; the timer restarts on every state change
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         timer_r <= TW'(0);
      end else begin
         state_r <= state_next_s;
         if (state_next_s != state_r) begin
            timer_r <= TW'(0);
         end else begin
            timer_r <= timer_r + TW'(1);
         end
      end
   end

   // Load context, word index and running write address
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r    <= CW'(0);
         rel_r      <= 1'b0;
         index_r    <= CW'(0);
         addr_acc_r <= XLEN'(0);
      end else if (start_ok_s) begin
         count_r    <= word_count;
         rel_r      <= release_en;
         index_r    <= CW'(0);
         addr_acc_r <= base_addr;
      end else begin
         if (advance_s) begin
            index_r <= index_r + CW'(1);
         end
         if (handshake_s) begin
            addr_acc_r <= addr_acc_r + XLEN'(ADDR_STEP);
         end
      end
   end

   // Registered outputs, decoded from the upcoming state so they line up with it
   always_ff @(posedge clk) begin
      if (rst) begin
         dbg_wr_en_r <= 1'b0;
         dbg_addr_r  <= XLEN'(0);
         dbg_instr_r <= XLEN'(0);
         core_rst_r  <= 1'b1;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         error_r     <= 1'b0;
      end else begin
         if (handshake_s) begin
            dbg_addr_r  <= addr_acc_r;
            dbg_instr_r <= in_data;
         end
         dbg_wr_en_r <= (state_next_s == ST_WRITE);
         busy_r      <= (state_next_s == ST_FETCH) || (state_next_s == ST_SETUP) ||
                        (state_next_s == ST_WRITE) || (state_next_s == ST_HOLD);
         done_r      <= (state_next_s == ST_FINISH);
         error_r     <= start_bad_s || abort_s;
         // A partial image must never run, so abort keeps the core in reset
         if (start_ok_s || abort_s) begin
            core_rst_r <= 1'b1;
         end else if (state_next_s == ST_FINISH) begin
            core_rst_r <= !rel_r;
         end else begin
            core_rst_r <= core_rst_r;
         end
      end
   end

   assign in_ready  = (state_r == ST_FETCH);
   assign dbg_wr_en = dbg_wr_en_r;
   assign dbg_addr  = dbg_addr_r;
   assign dbg_instr = dbg_instr_r;
   assign core_rst  = core_rst_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign error     = error_r;

endmodule

// File: tb/tb_dbg_program_loader.sv
// Testbench for dbg_program_loader: per-cycle traces of each load are compared against
// a cycle schedule derived from the word timing rules.
module tb_dbg_program_loader;

   localparam int XLEN   = 32;
   localparam int DEPTH  = 256;
   localparam int STEP   = 4;
   localparam int S      = 2;
   localparam int W      = 1;
   localparam int H      = 1;
   localparam int PERIOD = 1 + S + W + H;
   localparam int CW     = $clog2(DEPTH + 1);
   localparam int TRL    = 160;

   logic            clk = 1'b0;
   logic            rst, start, abort, release_en, in_valid;
   logic [XLEN-1:0] base_addr, in_data;
   logic [CW-1:0]   word_count;
   logic            in_ready, dbg_wr_en, core_rst, busy, done, error;
   logic [XLEN-1:0] dbg_addr, dbg_instr;

   int n_checks = 0;
   int n_fail   = 0;

   logic [XLEN-1:0] words [16];
   int              stall [16];
   logic            exp_core_rst;

   logic            tr_wr    [TRL];
   logic            tr_busy  [TRL];
   logic            tr_ready [TRL];
   logic            tr_err   [TRL];
   logic            tr_done  [TRL];
   logic            tr_rst   [TRL];
   logic [XLEN-1:0] tr_addr  [TRL];
   logic [XLEN-1:0] tr_instr [TRL];
   int              n_wr_rise, n_done, n_err;

   always #5 clk = ~clk;

   dbg_program_loader #(
      .XLEN(XLEN), .DEPTH(DEPTH), .ADDR_STEP(STEP),
      .SETUP_CYCLES(S), .WR_CYCLES(W), .HOLD_CYCLES(H)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .release_en(release_en),
      .base_addr(base_addr), .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .dbg_wr_en(dbg_wr_en), .dbg_addr(dbg_addr), .dbg_instr(dbg_instr),
      .core_rst(core_rst), .busy(busy), .done(done), .error(error)
   );

   // Issues a start, feeds words (respecting stall[] gaps) and records ncyc cycles of outputs.
   // Cycle 0 is the first cycle after the start edge.
   task automatic run_load(input logic [XLEN-1:0] b, input int n, input logic rel,
                           input int ncyc, input int abort_cyc, input int rst_cyc);
      int   wi;
      int   next_valid;
      logic prev_wr;
      @(posedge clk); #1;
      start      = 1'b1;
      base_addr  = b;
      word_count = CW'(n);
      release_en = rel;
      in_valid   = 1'b0;
      @(posedge clk); #1;
      start      = 1'b0;
      wi         = 0;
      next_valid = stall[0];
      prev_wr    = dbg_wr_en;
      n_wr_rise  = 0;
      n_done     = 0;
      n_err      = 0;
      for (int c = 0; c < ncyc; c++) begin
         abort    = (c == abort_cyc);
         rst      = (c == rst_cyc);
         in_valid = (wi < n) && (c >= next_valid);
         in_data  = words[wi % 16];
         @(negedge clk);
         tr_wr[c]    = dbg_wr_en;
         tr_busy[c]  = busy;
         tr_ready[c] = in_ready;
         tr_err[c]   = error;
         tr_done[c]  = done;
         tr_rst[c]   = core_rst;
         tr_addr[c]  = dbg_addr;
         tr_instr[c] = dbg_instr;
         if (dbg_wr_en && !prev_wr) n_wr_rise++;
         prev_wr = dbg_wr_en;
         if (done)  n_done++;
         if (error) n_err++;
         if (in_valid && in_ready) begin
            wi++;
            next_valid = c + PERIOD + stall[wi % 16];
         end
         @(posedge clk); #1;
      end
      abort    = 1'b0;
      rst      = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0; release_en = 1'b0; in_valid = 1'b0;
      base_addr = '0; word_count = '0; in_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready actual=%b expected=0", in_ready); end
      n_checks++; if (dbg_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en actual=%b expected=0", dbg_wr_en); end
      n_checks++; if (dbg_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr actual=%h expected=0", dbg_addr); end
      n_checks++; if (dbg_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr actual=%h expected=0", dbg_instr); end
      n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL reset_core_rst actual=%b expected=1", core_rst); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy actual=%b expected=0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done actual=%b expected=0", done); end
      n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error actual=%b expected=0", error); end
      @(posedge clk); #1;
      rst = 1'b0;
      exp_core_rst = 1'b1;
   endtask

   // Full load: schedule follows from handshake h[i] = h[i-1] + PERIOD + stall[i]
   task automatic test_load_image(input logic [XLEN-1:0] b, input int n, input logic rel, input string name);
      int h [16];
      int d, f, wc, last;
      logic [XLEN-1:0] ea;
      h[0] = stall[0];
      for (int i = 1; i < n; i++) h[i] = h[i-1] + PERIOD + stall[i];
      d = h[n-1] + PERIOD;
      run_load(b, n, rel, d + 4, -1, -1);
      n_checks++; if (n_wr_rise !== n) begin n_fail++; $display("FAIL %s write_count actual=%0d expected=%0d", name, n_wr_rise, n); end
      n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL %s done_count actual=%0d expected=1", name, n_done); end
      n_checks++; if (n_err !== 0) begin n_fail++; $display("FAIL %s error_count actual=%0d expected=0", name, n_err); end
      n_checks++; if (tr_rst[0] !== 1'b1) begin n_fail++; $display("FAIL %s core_rst_on_start actual=%b expected=1", name, tr_rst[0]); end
      n_checks++; if (tr_busy[0] !== 1'b1) begin n_fail++; $display("FAIL %s busy_rise actual=%b expected=1", name, tr_busy[0]); end
      for (int i = 0; i < n; i++) begin
         ea   = b + XLEN'(i * STEP);
         f    = (i == 0) ? 0 : h[i-1] + PERIOD;
         last = (i == n - 1) ? d + 3 : h[i+1];
         for (int c = f; c <= h[i]; c++) begin
            n_checks++; if (tr_ready[c] !== 1'b1) begin n_fail++; $display("FAIL %s ready_w%0d_c%0d actual=%b expected=1", name, i, c, tr_ready[c]); end
         end
         n_checks++; if (tr_ready[h[i]+1] !== 1'b0) begin n_fail++; $display("FAIL %s ready_drop_w%0d actual=%b expected=0", name, i, tr_ready[h[i]+1]); end
         for (int c = h[i] + 1; c <= last; c++) begin
            n_checks++; if (tr_addr[c] !== ea) begin n_fail++; $display("FAIL %s addr_w%0d_c%0d actual=%h expected=%h", name, i, c, tr_addr[c], ea); end
            n_checks++; if (tr_instr[c] !== words[i]) begin n_fail++; $display("FAIL %s instr_w%0d_c%0d actual=%h expected=%h", name, i, c, tr_instr[c], words[i]); end
         end
         wc = h[i] + 1 + S;
         n_checks++; if (tr_wr[wc-1] !== 1'b0) begin n_fail++; $display("FAIL %s wr_early_w%0d actual=%b expected=0", name, i, tr_wr[wc-1]); end
         for (int k = 0; k < W; k++) begin
            n_checks++; if (tr_wr[wc+k] !== 1'b1) begin n_fail++; $display("FAIL %s wr_pulse_w%0d actual=%b expected=1", name, i, tr_wr[wc+k]); end
         end
         n_checks++; if (tr_wr[wc+W] !== 1'b0) begin n_fail++; $display("FAIL %s wr_late_w%0d actual=%b expected=0", name, i, tr_wr[wc+W]); end
      end
      n_checks++; if (tr_done[d-1] !== 1'b0) begin n_fail++; $display("FAIL %s done_early actual=%b expected=0", name, tr_done[d-1]); end
      n_checks++; if (tr_done[d] !== 1'b1) begin n_fail++; $display("FAIL %s done_pulse actual=%b expected=1", name, tr_done[d]); end
      n_checks++; if (tr_done[d+1] !== 1'b0) begin n_fail++; $display("FAIL %s done_width actual=%b expected=0", name, tr_done[d+1]); end
      n_checks++; if (tr_busy[d-1] !== 1'b1) begin n_fail++; $display("FAIL %s busy_before_done actual=%b expected=1", name, tr_busy[d-1]); end
      n_checks++; if (tr_busy[d] !== 1'b0) begin n_fail++; $display("FAIL %s busy_at_done actual=%b expected=0", name, tr_busy[d]); end
      n_checks++; if (tr_rst[d-1] !== 1'b1) begin n_fail++; $display("FAIL %s core_rst_before_done actual=%b expected=1", name, tr_rst[d-1]); end
      n_checks++; if (tr_rst[d] !== !rel) begin n_fail++; $display("FAIL %s core_rst_at_done actual=%b expected=%b", name, tr_rst[d], !rel); end
      n_checks++; if (tr_rst[d+3] !== !rel) begin n_fail++; $display("FAIL %s core_rst_after actual=%b expected=%b", name, tr_rst[d+3], !rel); end
      exp_core_rst = !rel;
   endtask

   task automatic test_bad_count();
      int n;
      for (int k = 0; k < 2; k++) begin
         n = (k == 0) ? 0 : DEPTH + 1;
         run_load(32'h40, n, 1'b1, 6, -1, -1);
         n_checks++; if (tr_err[0] !== 1'b1) begin n_fail++; $display("FAIL bad_count_%0d error_pulse actual=%b expected=1", n, tr_err[0]); end
         n_checks++; if (n_err !== 1) begin n_fail++; $display("FAIL bad_count_%0d error_count actual=%0d expected=1", n, n_err); end
         n_checks++; if (n_wr_rise !== 0) begin n_fail++; $display("FAIL bad_count_%0d writes actual=%0d expected=0", n, n_wr_rise); end
         for (int c = 0; c < 6; c++) begin
            n_checks++; if (tr_busy[c] !== 1'b0) begin n_fail++; $display("FAIL bad_count_%0d busy_c%0d actual=%b expected=0", n, c, tr_busy[c]); end
            n_checks++; if (tr_rst[c] !== exp_core_rst) begin n_fail++; $display("FAIL bad_count_%0d core_rst_c%0d actual=%b expected=%b", n, c, tr_rst[c], exp_core_rst); end
            n_checks++; if (tr_ready[c] !== 1'b0) begin n_fail++; $display("FAIL bad_count_%0d ready_c%0d actual=%b expected=0", n, c, tr_ready[c]); end
         end
      end
   endtask

   task automatic test_abort();
      int a;
      for (int i = 0; i < 16; i++) begin stall[i] = 0; words[i] = $urandom; end
      a = PERIOD + 1 + S;
      run_load(32'h200, 4, 1'b1, a + 6, a, -1);
      n_checks++; if (tr_wr[a] !== 1'b1) begin n_fail++; $display("FAIL abort wr_before actual=%b expected=1", tr_wr[a]); end
      n_checks++; if (tr_wr[a+1] !== 1'b0) begin n_fail++; $display("FAIL abort wr_after actual=%b expected=0", tr_wr[a+1]); end
      n_checks++; if (tr_err[a] !== 1'b0) begin n_fail++; $display("FAIL abort error_early actual=%b expected=0", tr_err[a]); end
      n_checks++; if (tr_err[a+1] !== 1'b1) begin n_fail++; $display("FAIL abort error_pulse actual=%b expected=1", tr_err[a+1]); end
      n_checks++; if (tr_busy[a+1] !== 1'b0) begin n_fail++; $display("FAIL abort busy actual=%b expected=0", tr_busy[a+1]); end
      n_checks++; if (tr_ready[a+1] !== 1'b0) begin n_fail++; $display("FAIL abort ready actual=%b expected=0", tr_ready[a+1]); end
      n_checks++; if (tr_rst[a+1] !== 1'b1) begin n_fail++; $display("FAIL abort core_rst actual=%b expected=1", tr_rst[a+1]); end
      n_checks++; if (tr_rst[a+5] !== 1'b1) begin n_fail++; $display("FAIL abort core_rst_later actual=%b expected=1", tr_rst[a+5]); end
      n_checks++; if (tr_addr[a+1] !== 32'h204) begin n_fail++; $display("FAIL abort addr_hold actual=%h expected=00000204", tr_addr[a+1]); end
      n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL abort done_count actual=%0d expected=0", n_done); end
      n_checks++; if (n_err !== 1) begin n_fail++; $display("FAIL abort error_count actual=%0d expected=1", n_err); end
      n_checks++; if (n_wr_rise !== 2) begin n_fail++; $display("FAIL abort writes actual=%0d expected=2", n_wr_rise); end
      exp_core_rst = 1'b1;
      for (int i = 0; i < 16; i++) words[i] = $urandom;
      test_load_image(32'h300, 4, 1'b1, "after_abort");
   endtask

   task automatic test_rst_mid();
      for (int i = 0; i < 16; i++) begin stall[i] = 0; words[i] = $urandom | 32'h1; end
      run_load(32'h1000, 3, 1'b1, 6, -1, 1);
      n_checks++; if (tr_addr[1] !== 32'h1000) begin n_fail++; $display("FAIL rst_mid addr_before actual=%h expected=00001000", tr_addr[1]); end
      n_checks++; if (tr_addr[2] !== 32'h0) begin n_fail++; $display("FAIL rst_mid addr actual=%h expected=0", tr_addr[2]); end
      n_checks++; if (tr_instr[2] !== 32'h0) begin n_fail++; $display("FAIL rst_mid instr actual=%h expected=0", tr_instr[2]); end
      n_checks++; if (tr_wr[2] !== 1'b0) begin n_fail++; $display("FAIL rst_mid wr_en actual=%b expected=0", tr_wr[2]); end
      n_checks++; if (tr_rst[2] !== 1'b1) begin n_fail++; $display("FAIL rst_mid core_rst actual=%b expected=1", tr_rst[2]); end
      n_checks++; if (tr_busy[2] !== 1'b0) begin n_fail++; $display("FAIL rst_mid busy actual=%b expected=0", tr_busy[2]); end
      n_checks++; if (tr_done[2] !== 1'b0) begin n_fail++; $display("FAIL rst_mid done actual=%b expected=0", tr_done[2]); end
      n_checks++; if (tr_err[2] !== 1'b0) begin n_fail++; $display("FAIL rst_mid error actual=%b expected=0", tr_err[2]); end
      n_checks++; if (tr_ready[2] !== 1'b0) begin n_fail++; $display("FAIL rst_mid ready actual=%b expected=0", tr_ready[2]); end
      n_checks++; if (n_wr_rise !== 0) begin n_fail++; $display("FAIL rst_mid writes actual=%0d expected=0", n_wr_rise); end
      exp_core_rst = 1'b1;
   endtask

   task automatic test_random();
      int n;
      logic rel;
      for (int it = 0; it < 6; it++) begin
         n   = $urandom_range(1, 8);
         rel = 1'($urandom_range(0, 1));
         for (int i = 0; i < 16; i++) begin
            words[i] = $urandom;
            stall[i] = $urandom_range(0, 3);
         end
         test_load_image($urandom, n, rel, $sformatf("random_%0d", it));
      end
   endtask

   initial begin
      test_reset();
      for (int i = 0; i < 16; i++) begin stall[i] = 0; words[i] = 32'h0; end
      words[0] = 32'h00000093;
      words[1] = 32'h00C00093;
      words[2] = 32'h001020A3;
      test_load_image(32'h0, 3, 1'b1, "release");
      test_bad_count();
      test_load_image(32'h0, 3, 1'b0, "no_release");
      stall[1] = 7;
      test_load_image(32'h0, 3, 1'b1, "backpressure");
      test_abort();
      for (int i = 0; i < 16; i++) begin stall[i] = 0; words[i] = $urandom; end
      test_load_image(32'hFFFFFFFC, 2, 1'b1, "wrap");
      test_rst_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
